fft_in_framer: RTL and testbench
================================

FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 SHALL have parameter DW, default 9, sample component width (signed, two's complement).
REQ-002 SHALL have parameter N, default 32, FFT frame length in samples (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream sample valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a sample this cycle.
REQ-007 SHALL have ports in_re and in_im, input, DW each, signed sample real and imaginary parts.
REQ-008 SHALL have port valid_out, output, 1, drives the FFT valid_in; high for every streamed sample.
REQ-009 SHALL have ports out_re and out_im, output, DW each, signed sample to the FFT inputs FFTInRe and FFTInIm.
REQ-010 SHALL have port frame_start, output, 1, high with sample 0 of each frame.
REQ-011 SHALL have port frames_out, output, 8, count of frames fully streamed; wraps 255->0.

Function
REQ-012 SHALL hold two banks of N entries (bank0, bank1), each entry {re, im}, each bank with a full flag.
REQ-013 SHALL accept a sample on a cycle with in_valid and in_ready both high, writing it to the write bank at wr_ptr and then incrementing wr_ptr.
REQ-014 SHALL, on the accept that writes address N-1, set that bank's full flag, toggle the write bank and set wr_ptr to 0.
REQ-015 SHALL drive in_ready = !full[write bank] combinationally from registered flags, and SHALL drive it 0 while rst is high.
REQ-016 SHALL run a read FSM with states IDLE and STREAM.
REQ-017 SHALL, in IDLE, go to STREAM when full[read bank] is set; rd_ptr starts at 0.
REQ-018 SHALL, in STREAM, read one entry per cycle with no gaps; reading address N-1 clears that bank's full flag and toggles the read bank.
REQ-019 SHALL, after reading address N-1, stay in STREAM if the other bank is already full, giving back-to-back frames with valid_out continuously high; otherwise it SHALL return to IDLE.
REQ-020 SHALL register the output: valid_out, out_re, out_im and frame_start appear exactly 1 cycle after the corresponding read.
REQ-021 SHALL assert valid_out for sample 0 exactly 2 cycles after the edge that accepted sample N-1, when the read FSM was IDLE.
REQ-022 SHALL never assert valid_out for fewer than N consecutive cycles, and a frame, once started, SHALL never pause.
REQ-023 SHALL pass data through bit-exact, with no scaling or rounding, and SHALL drive out_re and out_im to 0 when valid_out is low.
REQ-024 SHALL handle simultaneous events on one edge: a bank set full by the write side and the other bank cleared by the read side both take effect.
REQ-025 SHALL make in_ready rise on the cycle after the clearing edge when the write side is blocked on the bank being released.
REQ-026 SHALL hold wr_ptr, stall the write side and drop nothing while in_valid is high and in_ready is low.
REQ-027 SHALL increment frames_out on the cycle valid_out is high for sample N-1.
REQ-028 SHALL keep a partially filled write bank indefinitely; there is no timeout and no partial-frame emission.

Reset
REQ-029 SHALL, when rst is high at an edge, make both full flags 0, wr_ptr and rd_ptr 0, both bank selects bank0, and the FSM IDLE.
REQ-030 SHALL, when rst is high at an edge, make valid_out, frame_start, out_re, out_im and frames_out 0.
REQ-031 SHALL, on a reset during STREAM, truncate the frame immediately: valid_out is 0 on the cycle after the reset edge, and bank contents are discarded.
REQ-032 SHALL not reset the bank storage.

Structure
REQ-033 SHALL place DW, N, LOG2N and the read FSM state encoding in the shared FFT package.
REQ-034 SHALL instantiate the sub-module fft_in_bank twice, one per bank: an N x 2*DW simple dual-port RAM with synchronous write and a 1-cycle synchronous read.

Verification
REQ-035 SHALL cover: reset, then 32 samples re=k, im=-k (k=0..31) with in_valid held high -> valid_out high 32 cycles starting 2 cycles after the 32nd accept, out_re=0..31 in order, frame_start only on k=0, frames_out=1.
REQ-036 SHALL cover: 64 samples continuous -> in_ready stays 1, 64 contiguous valid_out cycles, frame_start at output samples 0 and 32, frames_out=2.
REQ-037 SHALL cover: 96 samples pushed at full rate -> in_ready drops after the 64th accept and recovers exactly one cycle after bank0 is released, with no sample lost or duplicated.
REQ-038 SHALL cover: random in_valid gaps (about 50%) over 10 frames -> every frame contiguous and bit-exact with input order, frames_out=10.
REQ-039 SHALL cover: rst pulsed at output sample 10 of a frame -> valid_out=0 on the next cycle, in_ready=1 after reset, and a following full frame streams correctly with frames_out counting from 0.
REQ-040 SHALL cover: input values -256 and 255 -> output equals input exactly, with no sign corruption.

Source files
------------

// File: rtl/fft_in_framer_pkg.sv
// fft_in_framer_pkg: shared FFT framing parameters and read FSM encoding.
package fft_in_framer_pkg;
    localparam int DW = 9;
    localparam int N = 32;
    localparam int LOG2N = $clog2(N);
    typedef enum logic {IDLE, STREAM} rd_state_e;
endpackage

// File: rtl/fft_in_bank.sv
// fft_in_bank: simple dual-port frame RAM, synchronous write, 1-cycle synchronous read.
module fft_in_bank import fft_in_framer_pkg::*; #(
    parameter int W = 2 * DW,
    parameter int DEPTH = N,
    parameter int AW = LOG2N
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_in_framer.sv
// fft_in_framer: ping-pong frame buffer turning a gappy sample stream into
// gap-free N-sample frames for the FFT core.
module fft_in_framer #(
    parameter int DW = fft_in_framer_pkg::DW,
    parameter int N = fft_in_framer_pkg::N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          valid_out,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          frame_start,
    output logic [7:0]    frames_out
);
    import fft_in_framer_pkg::*;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    rd_state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, sel_q, sel_d;
    logic [1:0] full_q, full_d;
    logic valid_q, valid_d, fs_q, fs_d;
    logic [7:0] frames_q, frames_d;
    logic accept, wr_last, rd_en, rd_last;
    logic [2*DW-1:0] rdata [2];
    logic [2*DW-1:0] rd_word;

    always_comb begin
        in_ready = !rst && !full_q[wr_bank_q];
        accept = in_valid && in_ready;
        wr_last = accept && wr_ptr_q == LAST;
        rd_en = state_q == STREAM;
        rd_last = rd_en && rd_ptr_q == LAST;
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        wr_bank_d = wr_last ? !wr_bank_q : wr_bank_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : '0;
        rd_bank_d = rd_last ? !rd_bank_q : rd_bank_q;
        full_d = full_q;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        if (rd_last) full_d[rd_bank_q] = 1'b0;
        // At a frame boundary only an already-full partner bank keeps the stream going
        state_d = rd_last ? (full_q[!rd_bank_q] ? STREAM : IDLE)
                : (rd_en || full_q[rd_bank_q]) ? STREAM : IDLE;
        valid_d = rd_en;
        fs_d = rd_en && rd_ptr_q == '0;
        sel_d = rd_bank_q;
        frames_d = frames_q + 8'(rd_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            sel_q <= 1'b0;
            full_q <= '0;
            valid_q <= 1'b0;
            fs_q <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            sel_q <= sel_d;
            full_q <= full_d;
            valid_q <= valid_d;
            fs_q <= fs_d;
            frames_q <= frames_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_in_bank #(.W(2 * DW), .DEPTH(N), .AW(AW)) u_bank (
            .clk(clk),
            .we(accept && wr_bank_q == 1'(b)),
            .waddr(wr_ptr_q),
            .wdata({in_re, in_im}),
            .raddr(rd_ptr_q),
            .rdata(rdata[b])
        );
    end

    assign rd_word = sel_q ? rdata[1] : rdata[0];
    assign out_re = valid_q ? rd_word[2*DW-1:DW] : '0;
    assign out_im = valid_q ? rd_word[DW-1:0] : '0;
    assign valid_out = valid_q;
    assign frame_start = fs_q;
    assign frames_out = frames_q;
endmodule

// File: tb/tb_fft_in_framer.sv
// tb_fft_in_framer: directed checks of framing, back-pressure, reset and data integrity.
module tb_fft_in_framer;
    localparam int DW = 9;
    localparam int N = 32;
    logic clk = 0, rst = 1, in_valid = 0;
    logic in_ready, valid_out, frame_start;
    logic [DW-1:0] in_re = '0, in_im = '0, out_re, out_im;
    logic [7:0] frames_out;
    int cyc = 0, n_pass = 0, n_fail = 0, n_total = 0;
    int stalls = 0, stall_cyc = -1, last_acc = 0, fcnt = 0, gaps = 0, nz = 0;
    logic [2*DW-1:0] aq[$], oq[$];
    logic fsq[$];
    int cq[$], aeq[$];

    fft_in_framer #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .valid_out(valid_out), .out_re(out_re),
        .out_im(out_im), .frame_start(frame_start), .frames_out(frames_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid_out) begin
            oq.push_back({out_re, out_im});
            fsq.push_back(frame_start);
            cq.push_back(cyc);
        end else if (out_re != '0 || out_im != '0) nz++;
        if (rst) fcnt = 0;
        else if (valid_out) fcnt = (fcnt == N - 1) ? 0 : fcnt + 1;
        else if (fcnt != 0) gaps++;
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        aq.delete(); oq.delete(); fsq.delete(); cq.delete(); aeq.delete();
        stalls = 0; stall_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        clear_q();
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int w = 0;
        in_valid = 1; in_re = re; in_im = im;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            if (stall_cyc < 0) stall_cyc = cyc;
            w++; stalls++;
            @(negedge clk);
        end
        if (w == 200) check(in_ready, 1, "push_timeout");
        aq.push_back({re, im});
        last_acc = cyc + 1;
        aeq.push_back(last_acc);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frames(input int n);
        check(oq.size(), n, "out_count");
        for (int i = 0; i < n && i < oq.size() && i < aq.size(); i++) begin
            check(oq[i], aq[i], "data");
            check(fsq[i], (i % N) == 0, "frame_start");
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check(in_ready, 0, "rst_in_ready");
        check(valid_out, 0, "rst_valid");
        check(frames_out, 0, "rst_frames");
        check({out_re, out_im}, 0, "rst_out");
        rst = 0;
        #1 check(in_ready, 1, "post_rst_in_ready");
        clear_q();
        // one frame, re=k im=-k
        for (int k = 0; k < N; k++) push(DW'(k), DW'(-k));
        drain(40);
        check_frames(N);
        check(cq[0], last_acc + 2, "t1_latency");
        check(cq[N-1] - cq[0], N - 1, "t1_contig");
        check(frames_out, 1, "t1_frames");
        check(stalls, 0, "t1_stalls");
        // two back-to-back frames
        do_reset();
        for (int k = 0; k < 2 * N; k++) push(DW'(k + 7), DW'(3 * k));
        drain(70);
        check_frames(2 * N);
        check(stalls, 0, "t2_stalls");
        check(cq[2*N-1] - cq[0], 2 * N - 1, "t2_contig");
        check(frames_out, 2, "t2_frames");
        // three frames at full rate: one-cycle stall after the 64th accept
        do_reset();
        for (int k = 0; k < 3 * N; k++) push(DW'(5 * k), DW'(~k));
        drain(80);
        check_frames(3 * N);
        check(stalls, 1, "t3_stalls");
        check(stall_cyc, aeq[2*N-1], "t3_stall_cycle");
        check(aeq[2*N] - aeq[2*N-1], 2, "t3_recover");
        check(frames_out, 3, "t3_frames");
        // random gaps over ten frames
        do_reset();
        for (int k = 0; k < 10 * N; k++) begin
            repeat ($urandom_range(0, 1)) drain(1);
            push(DW'($urandom), DW'($urandom));
        end
        drain(80);
        check_frames(10 * N);
        check(frames_out, 10, "t4_frames");
        check(gaps, 0, "t4_gaps");
        // reset while sample 10 of a frame is on the output
        clear_q();
        for (int k = 0; k < N; k++) push(DW'(k), DW'(k));
        for (int w = 0; w < 100 && oq.size() < 10; w++) drain(1);
        check(valid_out, 1, "t5_pre_valid");
        check(out_re, 10, "t5_pre_sample");
        rst = 1;
        drain(1);
        check(valid_out, 0, "t5_trunc_valid");
        check(frames_out, 0, "t5_trunc_frames");
        check(in_ready, 0, "t5_rst_in_ready");
        @(negedge clk);
        #1 rst = 0;
        #1 check(in_ready, 1, "t5_in_ready");
        drain(1);
        clear_q();
        for (int k = 0; k < N; k++) push(DW'(100 + k), DW'(-k));
        drain(40);
        check_frames(N);
        check(cq[0], last_acc + 2, "t5_latency");
        check(frames_out, 1, "t5_frames");
        // extreme values
        clear_q();
        for (int k = 0; k < N; k++)
            push((k % 2) ? DW'(255) : DW'(-256), (k % 2) ? DW'(-256) : DW'(255));
        drain(40);
        check_frames(N);
        check({oq[0], oq[1]}, {9'h100, 9'h0FF, 9'h0FF, 9'h100}, "t6_extremes");
        check(frames_out, 2, "t6_frames");
        check(gaps, 0, "gaps_total");
        check(nz, 0, "idle_out_zero");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
